// File: rtl/mode_control_module_pkg.sv
// Shared constants and mode encoding for the hood controller mode logic.
package mode_control_module_pkg;

  localparam int unsigned MODE_WIDTH   = 3;
  localparam int unsigned MAX_WIDTH    = 8;
  localparam int unsigned COUNTER_1SEC = 49_999_999;

  typedef enum logic [MODE_WIDTH-1:0] {
    OFF_MODE     = 3'd0,
    STANDBY_MODE = 3'd1,
    FIRST_MODE   = 3'd2,
    SECOND_MODE  = 3'd3,
    THIRD_MODE   = 3'd4,
    CLEAN_MODE   = 3'd5
  } mode_e;

endpackage

// File: rtl/sec_countdown_module.sv
// Seconds countdown with a cycle prescaler; signals the tick that ends the countdown.
module sec_countdown_module
  import mode_control_module_pkg::*;
#(
  parameter int unsigned ONE_SEC_CNT = COUNTER_1SEC
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear,
  input  logic                 load,
  input  logic [MAX_WIDTH-1:0] load_value,
  input  logic                 run,
  output logic [MAX_WIDTH-1:0] remaining_sec,
  output logic                 done_c
);

  localparam int unsigned PW = (ONE_SEC_CNT < 1) ? 1 : $clog2(ONE_SEC_CNT + 1);

  logic [PW-1:0] prescaler;
  logic          tick_c;

  assign tick_c = (prescaler == PW'(ONE_SEC_CNT));
  assign done_c = run && tick_c && (remaining_sec == MAX_WIDTH'(1));

  // Clear beats load beats run; a zero load value still lasts one second.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prescaler     <= '0;
      remaining_sec <= '0;
    end else if (clear) begin
      prescaler     <= '0;
      remaining_sec <= '0;
    end else if (load) begin
      prescaler     <= '0;
      remaining_sec <= (load_value == '0) ? MAX_WIDTH'(1) : load_value;
    end else if (run) begin
      if (tick_c) begin
        prescaler <= '0;
        if (remaining_sec != '0) remaining_sec <= remaining_sec - MAX_WIDTH'(1);
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end else begin
      prescaler <= '0;
    end
  end

endmodule

// File: rtl/mode_control_module.sv
// Hood controller mode FSM: key pulses and power level to a registered mode code.
module mode_control_module
  import mode_control_module_pkg::*;
#(
  parameter int unsigned ONE_SEC_CNT = COUNTER_1SEC,
  parameter int unsigned THIRD_SEC   = 60,
  parameter int unsigned CLEAN_SEC   = 180
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  power_en,
  input  logic                  btn_standby,
  input  logic                  btn_first,
  input  logic                  btn_second,
  input  logic                  btn_third,
  input  logic                  btn_clean,
  output logic [MODE_WIDTH-1:0] current_mode,
  output logic [MAX_WIDTH-1:0]  remaining_sec,
  output logic                  third_used,
  output logic                  clean_done
);

  mode_e                state;
  mode_e                next_state;
  logic                 load_c;
  logic                 run_c;
  logic                 expire_c;
  logic [MAX_WIDTH-1:0] load_value_c;

  assign current_mode = state;
  assign run_c        = (state == THIRD_MODE) || (state == CLEAN_MODE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= OFF_MODE;
    else       state <= next_state;
  end

  // Next-state and countdown load control; power-off overrides everything.
  always_comb begin
    next_state   = state;
    load_c       = 1'b0;
    load_value_c = MAX_WIDTH'(CLEAN_SEC);
    if (!power_en) begin
      next_state = OFF_MODE;
    end else begin
      unique case (state)
        OFF_MODE: next_state = STANDBY_MODE;
        STANDBY_MODE: begin
          if (btn_standby)                   next_state = STANDBY_MODE;
          else if (btn_clean)                next_state = CLEAN_MODE;
          else if (btn_third && !third_used) next_state = THIRD_MODE;
          else if (btn_second)               next_state = SECOND_MODE;
          else if (btn_first)                next_state = FIRST_MODE;
        end
        FIRST_MODE, SECOND_MODE: begin
          if (btn_standby)                   next_state = STANDBY_MODE;
          else if (btn_third && !third_used) next_state = THIRD_MODE;
          else if (btn_second)               next_state = SECOND_MODE;
          else if (btn_first)                next_state = FIRST_MODE;
        end
        THIRD_MODE: if (expire_c) next_state = SECOND_MODE;
        CLEAN_MODE: if (expire_c) next_state = STANDBY_MODE;
        default:    next_state = OFF_MODE;
      endcase
      if (next_state != state) begin
        if (next_state == THIRD_MODE) begin
          load_c       = 1'b1;
          load_value_c = MAX_WIDTH'(THIRD_SEC);
        end else if (next_state == CLEAN_MODE) begin
          load_c = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      third_used <= 1'b0;
      clean_done <= 1'b0;
    end else begin
      clean_done <= power_en && (state == CLEAN_MODE) && expire_c;
      if (!power_en)                                             third_used <= 1'b0;
      else if (next_state == THIRD_MODE && state != THIRD_MODE) third_used <= 1'b1;
    end
  end

  sec_countdown_module #(
    .ONE_SEC_CNT(ONE_SEC_CNT)
  ) u_countdown (
    .clk          (clk),
    .rstn         (rstn),
    .clear        (!power_en),
    .load         (load_c),
    .load_value   (load_value_c),
    .run          (run_c),
    .remaining_sec(remaining_sec),
    .done_c       (expire_c)
  );

endmodule

// File: doc/mode_control_module.md
Name: mode_control_module

Overview:
- Central mode state machine of the hood controller.
- Turns debounced single-cycle key pulses and the power level into the registered `current_mode` code.
- Downstream per-mode event/timing modules consume `current_mode` and count seconds while their mode is active.
- Owns the timed modes: third mode (hurricane, limited to one use per power-on) and clean mode, each with a seconds countdown.

Parameters:
- ONE_SEC_CNT, default `COUNTER_1SEC: terminal value of the cycle prescaler. One tick occurs every ONE_SEC_CNT+1 cycles, matching the downstream second counters.
- THIRD_SEC, default 60: third-mode duration in seconds.
- CLEAN_SEC, default 180: clean-mode duration in seconds.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- power_en  in  1  level; 1 = hood powered
- btn_standby  in  1  one-cycle pulse
- btn_first  in  1  one-cycle pulse
- btn_second  in  1  one-cycle pulse
- btn_third  in  1  one-cycle pulse
- btn_clean  in  1  one-cycle pulse
- current_mode  out  `MODE_WIDTH  registered mode code
- remaining_sec  out  `MAX_WIDTH  seconds left in the active timed mode, else 0
- third_used  out  1  third mode consumed since power-on
- clean_done  out  1  one-cycle pulse when clean mode finishes

Behaviour:
- Clock and reset: one clock, clk. rstn is asynchronous and active-low.
- Reset values: current_mode=`OFF_MODE, remaining_sec=0, third_used=0, clean_done=0, prescaler=0.
- Latency: every output is registered. A key pulse in cycle N changes the outputs at edge N+1.
- power_en=0, in any state: next cycle is OFF. Prescaler, remaining_sec and third_used clear. power_en has priority over every key.
- OFF: power_en=1 goes to STANDBY.
- Key priority when several pulses coincide: standby > clean > third > second > first.
- STANDBY transitions:
  - first -> FIRST
  - second -> SECOND
  - third -> THIRD, only if third_used=0
  - clean -> CLEAN
  - standby -> no change
- FIRST/SECOND transitions:
  - first/second switch between the two
  - standby -> STANDBY
  - third -> THIRD, only if third_used=0
  - clean ignored (clean is entered only from STANDBY)
- THIRD:
  - On entry: remaining_sec=THIRD_SEC, prescaler=0, third_used=1.
  - Each tick decrements remaining_sec.
  - A tick with remaining_sec=1 gives SECOND with remaining_sec=0.
  - All keys are ignored, including standby; the only exits are timeout or power-off.
- CLEAN:
  - On entry: remaining_sec=CLEAN_SEC, prescaler=0.
  - Each tick decrements remaining_sec.
  - A tick with remaining_sec=1 gives STANDBY, remaining_sec=0, and clean_done=1 for exactly one cycle.
  - All keys are ignored.
- Prescaler:
  - Counts only in THIRD/CLEAN.
  - tick = (prescaler==ONE_SEC_CNT), after which the prescaler goes to 0.
  - Held at 0 in every other state.
- remaining_sec never wraps below 0. A parameter of 0 is treated as 1.
- third_used is sticky until power-off or reset; THIRD→SECOND timeout does not clear it.
- Keys arriving in the same cycle as a timeout transition are ignored.
- Reset mid-countdown returns to OFF immediately, asynchronously.
- An unused mode encoding recovers to OFF on the next clock.

Decomposition:
- Into header_files/parameters.vh, as shared constants:
  - `MODE_WIDTH=3
  - `OFF_MODE=0, `STANDBY_MODE=1, `FIRST_MODE=2, `SECOND_MODE=3, `THIRD_MODE=4, `CLEAN_MODE=5
  - `COUNTER_1SEC and `MAX_WIDTH
- One natural sub-module: sec_countdown_module.
  - Inputs: load, load_value, run.
  - Contains the prescaler and remaining_sec decrement.
  - Outputs: remaining_sec and a one-cycle done pulse.
  - The FSM itself stays in mode_control_module.

Test Plan (ONE_SEC_CNT=3, i.e. 4 cycles/s; THIRD_SEC=2; CLEAN_SEC=3):
- Reset, then power_en=1 → STANDBY (1) one cycle later. btn_first → FIRST (2). btn_second → SECOND (3). btn_standby → STANDBY.
- From FIRST, btn_third → THIRD (4), remaining_sec=2, third_used=1. After 4 cycles remaining_sec=1. After 8 cycles mode=SECOND, remaining_sec=0. A second btn_third stays in SECOND.
- From STANDBY, btn_clean → CLEAN (5), remaining_sec=3. btn_first mid-countdown is ignored. After 12 cycles mode=STANDBY and clean_done pulses for 1 cycle.
- btn_standby and btn_third in the same cycle from FIRST → STANDBY. btn_third and btn_second together with third_used=0 → THIRD.
- power_en=0 during THIRD → OFF next cycle, remaining_sec=0, third_used=0. Power back on, then btn_third → THIRD is accepted again.
- rstn asserted asynchronously mid-CLEAN → outputs go to reset values without a clock edge. No clean_done pulse.
